lsu_mem_ctrl: RTL

//  Load/store controller between the core's memory stage and the single-port, word-wide data memory.

---
 rtl/lsu_mem_ctrl_pkg.sv | 38 +++
 rtl/lsu_mem_ctrl_align.sv | 59 +++++
 rtl/lsu_mem_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store memory controller:
// funct3 codes, FSM states and the request legality check.
package lsu_mem_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP,
        S_ERR
    } state_t;

    // Illegal funct3, misalignment or out-of-range address.
    function automatic logic req_bad(
        input logic        we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [31:0] limit
    );
        logic bad;
        bad = 1'b0;
        if (addr >= limit) bad = 1'b1;
        if (!we && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111))
            bad = 1'b1;
        if (we && f3 > F3_W) bad = 1'b1;
        if ((f3 == F3_H || f3 == F3_HU) && addr[0]) bad = 1'b1;
        if (f3 == F3_W && addr[1:0] != 2'b00) bad = 1'b1;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// Byte/halfword lane handling: load extraction with sign/zero
// extension and sub-word merge for read-modify-write stores.
module lsu_mem_ctrl_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o,
    output logic [31:0] wword_o
);

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [2:0]  f3
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_BU:   r = {24'd0, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  lane,
        input logic [2:0]  f3
    );
        logic [31:0] r;
        r = word;
        case (f3)
            F3_B: r[{lane, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Both lane views of the captured word, chosen by the FSM.
    always_comb begin
        rdata_o = extract(word_i, lane_i, funct3_i);
        wword_o = merge(word_i, wdata_i, lane_i, funct3_i);
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: request latch, captured word and the
// FSM sequencing word reads/writes to a single-port memory.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int MEM_WORDS = 64,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [31:0]      rsp_rdata,
    output logic             busy,
    output logic             mem_en,
    output logic             mem_we,
    output logic [IDX_W-1:0] mem_idx,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam logic [31:0] LIMIT = 32'(4 * MEM_WORDS);

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [IDX_W+1:0]  addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       word_q;
    logic [31:0]       ext_rdata;
    logic [31:0]       mrg_word;
    logic              accept;
    logic              en_c;
    logic              we_c;

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state_q != S_IDLE);
    assign mem_en    = en_c && !reset;
    assign mem_we    = we_c && !reset;

    lsu_mem_ctrl_align u_align (
        .word_i   (word_q),
        .wdata_i  (wdata_q),
        .lane_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .rdata_o  (ext_rdata),
        .wword_o  (mrg_word)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Latch the request on accept and capture the read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            word_q  <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[IDX_W+1:0];
                wdata_q <= req_wdata;
            end
            if (state_q == S_CAP) word_q <= mem_rdata;
        end
    end

    // Next state, memory strobes and response outputs.
    always_comb begin
        state_d   = state_q;
        en_c      = 1'b0;
        we_c      = 1'b0;
        mem_idx   = '0;
        mem_wdata = 32'd0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = 32'd0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad(req_we, req_funct3, req_addr, LIMIT))
                        state_d = S_ERR;
                    else if (req_we && req_funct3 == F3_W)
                        state_d = S_WR;
                    else
                        state_d = S_RD;
                end
            end
            S_RD: begin
                en_c    = 1'b1;
                mem_idx = addr_q[IDX_W+1:2];
                state_d = S_CAP;
            end
            S_CAP: begin
                state_d = we_q ? S_WR : S_RESP;
            end
            S_WR: begin
                en_c      = 1'b1;
                we_c      = 1'b1;
                mem_idx   = addr_q[IDX_W+1:2];
                mem_wdata = (f3_q == F3_W) ? wdata_q : mrg_word;
                state_d   = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_rdata = we_q ? 32'd0 : ext_rdata;
                state_d   = S_IDLE;
            end
            S_ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
